// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants, instruction field positions and FSM state type for the fetch stage
package ifetch_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'd14;
    localparam logic [5:0] OP_CLL = 6'd15;

    // Instruction layout: {opcode, Rd, Rs, Rt, imm14}
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 18;
    localparam int RT_MSB     = 17;
    localparam int RT_LSB     = 14;
    localparam int IMM_MSB    = 13;
    localparam int IMM_LSB    = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/jump_target_calc.sv
// rtl/jump_target_calc.sv - flags J/CLL opcodes and computes pc + (sext(imm14) << 2)
module jump_target_calc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [13:0] imm,
    output logic        is_jump,
    output logic [31:0] target
);

    // Word-granular signed offset; the add wraps modulo 2^32.
    always_comb begin
        is_jump = (opcode == OP_J) || (opcode == OP_CLL);
        target  = pc + {{16{imm[13]}}, imm, 2'b00};
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner and IF/ID register; IFETCH_EARLY_JUMP_EN enables IF-stage J/CLL redirect
module fetch_controller
    import ifetch_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        resume,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_predicted,
    output logic        halted
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic [31:0]  ifpc4_q, ifpc4_d;
    logic         pred_q, pred_d;

    logic [31:0]  pc_plus4;
    logic         jump_taken;
    logic [31:0]  jump_target;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_EARLY_JUMP_EN
    jump_target_calc u_jump_target_calc (
        .pc      (pc_q),
        .opcode  (imem_rdata[OPCODE_MSB:OPCODE_LSB]),
        .imm     (imem_rdata[IMM_MSB:IMM_LSB]),
        .is_jump (jump_taken),
        .target  (jump_target)
    );
`else
    assign jump_taken  = 1'b0;
    assign jump_target = pc_plus4;
`endif

    // Next state: redirect beats stall, stall freezes everything, then halt/flush/sequential fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        pred_d  = pred_q;

        if (redirect_valid) begin
            // Wrong-path fetches may have halted, so a redirect always restarts the FSM.
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pred_d  = 1'b0;
        end else if (stall) begin
            state_d = state_q;
        end else if (state_q == HALT) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pred_d  = 1'b0;
            if (resume) begin
                state_d = RUN;
                pc_d    = pc_plus4;
            end
        end else if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pred_d  = 1'b0;
            pc_d    = pc_plus4;
        end else if ((imem_rdata == HALT_WORD) || (pc_q >= PC_LIMIT)) begin
            // Range check comes before any pc+4 so the PC can never wrap past the end.
            state_d = HALT;
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pred_d  = 1'b0;
        end else begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            pred_d  = jump_taken;
            pc_d    = jump_taken ? jump_target : pc_plus4;
        end
    end

    // State and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            ifpc_q  <= 32'h0;
            ifpc4_q <= 32'h0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            pred_q  <= pred_d;
        end
    end

    assign imem_addr       = pc_q;
    assign if_id_valid     = valid_q;
    assign if_id_instr     = instr_q;
    assign if_id_pc        = ifpc_q;
    assign if_id_pc_plus4  = ifpc4_q;
    assign if_id_predicted = pred_q;
    assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller (64-word memory)
module tb_fetch_controller;

    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_predicted;
    logic        halted;

    logic [31:0] mem [0:WORDS-1];

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pred;
        logic        halted;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

`ifdef IFETCH_EARLY_JUMP_EN
    localparam logic        JPRED = 1'b1;
    localparam logic [31:0] JNEXT = 32'd92;
`else
    localparam logic        JPRED = 1'b0;
    localparam logic [31:0] JNEXT = 32'd84;
`endif

    fetch_controller #(
        .IMEM_WORDS (WORDS),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .resume          (resume),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_predicted (if_id_predicted),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Addresses past the end alias back into the array so only the range check can stop them.
    assign imem_rdata = mem[imem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected IF/ID and PC, clock, then compare.
    task automatic step(input logic rst, input logic st, input logic fl, input logic rv,
                        input logic [31:0] rpc, input logic rs,
                        input logic ev, input logic [31:0] epc, input logic [31:0] epc4,
                        input logic ep, input logic eh, input logic [31:0] eaddr,
                        input string tag);
        exp_t e;
        reset          = rst;
        stall          = st;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        resume         = rs;
        e.valid  = ev;
        e.instr  = ev ? mem[epc[7:2]] : 32'h0;
        e.pc     = epc;
        e.pc4    = epc4;
        e.pred   = ep;
        e.halted = eh;
        e.addr   = eaddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid"},  {31'd0, if_id_valid},     {31'd0, e.valid});
            check({tag, ".instr"},  if_id_instr,              e.instr);
            check({tag, ".pc"},     if_id_pc,                 e.pc);
            check({tag, ".pc4"},    if_id_pc_plus4,           e.pc4);
            check({tag, ".pred"},   {31'd0, if_id_predicted}, {31'd0, e.pred});
            check({tag, ".halted"}, {31'd0, halted},          {31'd0, e.halted});
            check({tag, ".addr"},   imem_addr,                e.addr);
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = {6'd1, 4'd1, 4'd0, 4'd0, 14'(i)};
        end
        mem[3]  = 32'hFFFF_FFFF;
        mem[20] = {6'd14, 4'd0, 4'd0, 4'd0, 14'd3};

        //    rst st fl rv rpc       rs  v  if_pc   pc4     p      h  addr
        step(1, 0, 0, 0, 32'h0,  0,  0, 32'd0,  32'd0,  1'b0,  0, 32'd0,  "reset0");
        step(1, 0, 0, 0, 32'h0,  0,  0, 32'd0,  32'd0,  1'b0,  0, 32'd0,  "reset1");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd0,  32'd4,  1'b0,  0, 32'd4,  "seq0");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd4,  32'd8,  1'b0,  0, 32'd8,  "seq1");
        step(0, 1, 0, 0, 32'h0,  0,  1, 32'd4,  32'd8,  1'b0,  0, 32'd8,  "stall0");
        step(0, 1, 0, 0, 32'h0,  0,  1, 32'd4,  32'd8,  1'b0,  0, 32'd8,  "stall1");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd8,  32'd12, 1'b0,  0, 32'd12, "seq2");
        step(0, 0, 0, 0, 32'h0,  0,  0, 32'd8,  32'd12, 1'b0,  1, 32'd12, "halt_word");
        step(0, 0, 0, 0, 32'h0,  0,  0, 32'd8,  32'd12, 1'b0,  1, 32'd12, "halt_hold");
        step(0, 0, 0, 1, 32'h0,  1,  0, 32'd8,  32'd12, 1'b0,  0, 32'd0,  "halt_redir");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd0,  32'd4,  1'b0,  0, 32'd4,  "rerun0");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd4,  32'd8,  1'b0,  0, 32'd8,  "rerun1");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd8,  32'd12, 1'b0,  0, 32'd12, "rerun2");
        step(0, 0, 0, 0, 32'h0,  0,  0, 32'd8,  32'd12, 1'b0,  1, 32'd12, "halt_again");
        step(0, 0, 0, 0, 32'h0,  1,  0, 32'd8,  32'd12, 1'b0,  0, 32'd16, "resume");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd16, 32'd20, 1'b0,  0, 32'd20, "after_resume");
        step(0, 1, 0, 1, 32'h43, 0,  0, 32'd16, 32'd20, 1'b0,  0, 32'h40, "redir_stall");
        step(0, 0, 1, 0, 32'h0,  0,  0, 32'd16, 32'd20, 1'b0,  0, 32'h44, "flush");
        step(0, 1, 1, 0, 32'h0,  0,  0, 32'd16, 32'd20, 1'b0,  0, 32'h44, "flush_stall");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'h44, 32'h48, 1'b0,  0, 32'h48, "post_flush");
        step(0, 0, 0, 1, 32'd80, 0,  0, 32'h44, 32'h48, 1'b0,  0, 32'd80, "to_jump");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd80, 32'd84, JPRED, 0, JNEXT,  "jump");
        step(0, 0, 0, 1, 32'd248,0,  0, 32'd80, 32'd84, 1'b0,  0, 32'd248,"to_end");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd248,32'd252,1'b0,  0, 32'd252,"end0");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd252,32'd256,1'b0,  0, 32'd256,"end1");
        step(0, 0, 0, 0, 32'h0,  0,  0, 32'd252,32'd256,1'b0,  1, 32'd256,"range_halt");
        step(0, 0, 0, 0, 32'h0,  0,  0, 32'd252,32'd256,1'b0,  1, 32'd256,"range_hold");
        step(1, 0, 0, 0, 32'h0,  0,  0, 32'd0,  32'd0,  1'b0,  0, 32'd0,  "mid_reset");
        step(0, 0, 0, 0, 32'h0,  0,  1, 32'd0,  32'd4,  1'b0,  0, 32'd4,  "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
